// File: rtl/weightbuffer_ctrl_pkg.sv
// Shared types and sizing helpers for the weight-buffer load controller.
package weightbuffer_ctrl_pkg;

    // Load sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_FLUSH  = 2'd3
    } state_e;

    // Kernel width in bits: layout [K][K][N_I][2]
    function automatic int unsigned wb_w(input int unsigned n_i, input int unsigned k);
        return k * k * n_i * 2;
    endfunction

    // Width able to hold an OCU count from 0 to n_o inclusive
    function automatic int unsigned cnt_w(input int unsigned n_o);
        return $clog2(n_o + 1);
    endfunction

endpackage

// File: rtl/wb_onehot_dec.sv
// Index to one-hot decoder for the per-block save enables; out-of-range indices decode to zero.
module wb_onehot_dec
    import weightbuffer_ctrl_pkg::*;
#(
    parameter int unsigned N_O   = 64,
    parameter int unsigned CNT_W = cnt_w(N_O)
) (
    input  logic [CNT_W-1:0] idx_i,
    input  logic             en_i,
    output logic [N_O-1:0]   onehot_o
);

    // One bit per block, set only when enabled and the index matches
    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < N_O; i++) begin
            if (en_i && (idx_i == CNT_W'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/weightbuffer_load_ctrl.sv
// Streams kernels into the per-OCU weight buffer latch arrays, one block per accepted beat,
// and issues a global flush on request.
module weightbuffer_load_ctrl
    import weightbuffer_ctrl_pkg::*;
#(
    parameter int unsigned N_O   = 64,
    parameter int unsigned N_I   = 512,
    parameter int unsigned K     = 3,
    parameter int unsigned CNT_W = cnt_w(N_O)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [CNT_W-1:0]          n_o_cfg_i,
    input  logic                      flush_req_i,
    input  logic                      weights_valid_i,
    output logic                      weights_ready_o,
    input  logic [wb_w(N_I, K)-1:0]   weights_data_i,
    output logic [wb_w(N_I, K)-1:0]   wb_data_o,
    output logic [N_O-1:0]            wb_save_o,
    output logic                      wb_flush_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int unsigned DW = wb_w(N_I, K);

    state_e           state_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] idx_q;
    logic [DW-1:0]    data_q;
    logic [N_O-1:0]   save_q;
    logic             flush_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic [CNT_W-1:0] n_clamp;
    logic [CNT_W-1:0] idx_d;
    logic [N_O-1:0]   save_d;

    // A flush request in LOAD withholds ready so no beat slips in alongside the abort
    assign weights_ready_o = (state_q == ST_LOAD) && !flush_req_i;
    assign accept          = weights_ready_o && weights_valid_i;
    assign n_clamp         = (n_o_cfg_i > CNT_W'(N_O)) ? CNT_W'(N_O) : n_o_cfg_i;
    assign idx_d           = idx_q + CNT_W'(1);

    wb_onehot_dec #(
        .N_O   (N_O),
        .CNT_W (CNT_W)
    ) u_save_dec (
        .idx_i    (idx_q),
        .en_i     (accept),
        .onehot_o (save_d)
    );

    // Sequencer with registered data/save/flush/busy/done so the latches see stable values
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            save_q  <= '0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            save_q  <= save_d;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            if (accept) begin
                data_q <= weights_data_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (flush_req_i) begin
                        state_q <= ST_FLUSH;
                        flush_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (start_i) begin
                        n_q    <= n_clamp;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                        if (n_clamp == '0) begin
                            state_q <= ST_COMMIT;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (flush_req_i) begin
                        state_q <= ST_FLUSH;
                        flush_q <= 1'b1;
                    end else if (accept) begin
                        idx_q <= idx_d;
                        if (idx_d == n_q) begin
                            state_q <= ST_COMMIT;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (flush_req_i) begin
                        state_q <= ST_FLUSH;
                        flush_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wb_data_o  = data_q;
    assign wb_save_o  = save_q;
    assign wb_flush_o = flush_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_weightbuffer_load_ctrl.sv
// Bench for weightbuffer_load_ctrl with a small configuration (4 OCUs, 32-bit kernels).
module tb_weightbuffer_load_ctrl;

    localparam int unsigned N_O   = 4;
    localparam int unsigned N_I   = 4;
    localparam int unsigned K     = 2;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned DW    = K * K * N_I * 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] n_cfg;
    logic             flush;
    logic             valid;
    logic             ready;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    wb_data;
    logic [N_O-1:0]   wb_save;
    logic             wb_flush;
    logic             busy;
    logic             done;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [DW-1:0]    data_exp = '0;

    weightbuffer_load_ctrl #(
        .N_O (N_O),
        .N_I (N_I),
        .K   (K)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .n_o_cfg_i       (n_cfg),
        .flush_req_i     (flush),
        .weights_valid_i (valid),
        .weights_ready_o (ready),
        .weights_data_i  (wdata),
        .wb_data_o       (wb_data),
        .wb_save_o       (wb_save),
        .wb_flush_o      (wb_flush),
        .busy_o          (busy),
        .done_o          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Check every output at the falling edge, then advance to just after the next rising edge
    task automatic step(input string tag, input bit e_rdy, input logic [N_O-1:0] e_save,
                        input bit e_flush, input bit e_busy, input bit e_done);
        @(negedge clk);
        chk({tag, ".ready"}, DW'(ready), DW'(e_rdy));
        chk({tag, ".save"},  DW'(wb_save), DW'(e_save));
        chk({tag, ".data"},  wb_data, data_exp);
        chk({tag, ".flush"}, DW'(wb_flush), DW'(e_flush));
        chk({tag, ".busy"},  DW'(busy), DW'(e_busy));
        chk({tag, ".done"},  DW'(done), DW'(e_done));
        @(posedge clk);
        #1;
    endtask

    // One load transaction: beat k of min(cfg,N_O) goes to block k, saved the cycle after acceptance.
    // flush_at >= 0 requests a flush once that many beats have been accepted.
    task automatic run_load(input int cfg, input int flush_at, input logic [31:0] vpat, input bit rnd);
        int             n;
        int             acc;
        int             cyc;
        bit             fl;
        bit             acc_now;
        logic [N_O-1:0] pend;
        n    = (cfg > int'(N_O)) ? int'(N_O) : cfg;
        acc  = 0;
        cyc  = 0;
        pend = '0;
        start = 1'b1;
        n_cfg = CNT_W'(cfg);
        valid = 1'b0;
        flush = 1'b0;
        step("start", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        if (n == 0) begin
            valid = 1'b1;
            step("commit0", 1'b0, '0, 1'b0, 1'b1, 1'b1);
            valid = 1'b0;
            step("idle0", 1'b0, '0, 1'b0, 1'b0, 1'b0);
            return;
        end
        while (cyc < 200) begin
            fl      = (flush_at >= 0) && (acc == flush_at);
            valid   = fl ? 1'b1 : (rnd ? ($urandom_range(0, 2) != 0) : vpat[cyc]);
            wdata   = DW'($urandom);
            start   = 1'($urandom_range(0, 1));
            n_cfg   = CNT_W'($urandom);
            flush   = fl;
            acc_now = valid && !fl;
            step("load", !fl, pend, 1'b0, 1'b1, 1'b0);
            start = 1'b0;
            flush = 1'b0;
            valid = 1'b0;
            pend  = acc_now ? N_O'(1 << acc) : '0;
            if (acc_now) begin
                data_exp = wdata;
                acc++;
            end
            cyc++;
            if (fl) begin
                valid = 1'b1;
                step("flush", 1'b0, '0, 1'b1, 1'b1, 1'b0);
                valid = 1'b0;
                step("after_flush", 1'b0, '0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (acc == n) begin
                start = 1'b1;
                n_cfg = CNT_W'(2);
                valid = 1'b1;
                step("commit", 1'b0, pend, 1'b0, 1'b1, 1'b1);
                start = 1'b0;
                valid = 1'b0;
                step("after_commit", 1'b0, '0, 1'b0, 1'b0, 1'b0);
                return;
            end
        end
        chk("load_timeout", DW'(cyc), DW'(0));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        n_cfg = '0;
        flush = 1'b0;
        valid = 1'b0;
        wdata = '0;
        #3;
        chk("rst.ready", DW'(ready), '0);
        chk("rst.save",  DW'(wb_save), '0);
        chk("rst.data",  wb_data, '0);
        chk("rst.flush", DW'(wb_flush), '0);
        chk("rst.busy",  DW'(busy), '0);
        chk("rst.done",  DW'(done), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Back-to-back full load
        run_load(4, -1, 32'hFFFF_FFFF, 1'b0);
        // Gapped valid: beats on load cycles 0, 3, 4
        run_load(3, -1, 32'b11001, 1'b0);
        // Flush after two of four beats
        run_load(4, 2, 32'hFFFF_FFFF, 1'b0);

        // Start and flush together in IDLE: flush wins
        start = 1'b1;
        n_cfg = CNT_W'(4);
        flush = 1'b1;
        step("sf.req", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        flush = 1'b0;
        valid = 1'b1;
        step("sf.flush", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        valid = 1'b0;
        step("sf.idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Zero-length load and clamped oversize load
        run_load(0, -1, 32'hFFFF_FFFF, 1'b0);
        run_load(7, -1, 32'hFFFF_FFFF, 1'b0);

        // Random loads with random gaps and occasional aborts
        for (int i = 0; i < 8; i++) begin
            int cfg;
            int fa;
            cfg = int'($urandom_range(0, 7));
            fa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_load(cfg, fa, 32'h0, 1'b1);
        end

        // Asynchronous reset mid-load after one accepted beat
        start = 1'b1;
        n_cfg = CNT_W'(4);
        step("mr.start", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        valid = 1'b1;
        wdata = DW'($urandom);
        step("mr.beat", 1'b1, '0, 1'b0, 1'b1, 1'b0);
        valid    = 1'b0;
        data_exp = wdata;
        chk("mr.save_before", DW'(wb_save), DW'(4'b0001));
        #1;
        rst = 1'b1;
        #1;
        data_exp = '0;
        chk("mr.ready", DW'(ready), '0);
        chk("mr.save",  DW'(wb_save), '0);
        chk("mr.data",  wb_data, '0);
        chk("mr.flush", DW'(wb_flush), '0);
        chk("mr.busy",  DW'(busy), '0);
        chk("mr.done",  DW'(done), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("mr.idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        run_load(2, -1, 32'hFFFF_FFFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
